// File: rtl/ara_irq_pkg.sv
// Shared definitions for the ara_irq_router interrupt block:
// register word offsets, gateway state encoding and the id-width helper.
package ara_irq_pkg;

  // Base word indices of the register windows
  localparam logic [7:0] REG_PRIO     = 8'h00;
  localparam logic [7:0] REG_ENABLE   = 8'h20;
  localparam logic [7:0] REG_THRESH   = 8'h40;
  localparam logic [7:0] REG_CLAIM    = 8'h60;
  localparam logic [7:0] REG_MSIP     = 8'h80;
  localparam logic [7:0] REG_MTIME_LO = 8'hA0;
  localparam logic [7:0] REG_MTIME_HI = 8'hA1;
  localparam logic [7:0] REG_MTIMECMP = 8'hB0;

  // Per-source gateway state
  typedef enum logic [1:0] {
    GW_IDLE     = 2'd0,
    GW_PENDING  = 2'd1,
    GW_INFLIGHT = 2'd2
  } gw_state_e;

  // Bits needed to encode values 0..n-1 (minimum 1)
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ara_irq_arbiter.sv
// Per-context selection: among pending and enabled sources whose priority
// exceeds the context threshold, pick the highest priority; on a tie the
// lowest id wins. Purely combinational; id 0 means nothing qualifies.
module ara_irq_arbiter
  import ara_irq_pkg::*;
#(
  parameter int NrSources = 8,
  parameter int PrioWidth = 3,
  parameter int IdW       = clog2(NrSources + 1)
) (
  input  logic [NrSources-1:0]                pending,
  input  logic [NrSources-1:0]                enable,
  input  logic [NrSources-1:0][PrioWidth-1:0] prio,
  input  logic [PrioWidth-1:0]                thresh,
  output logic [IdW-1:0]                      id,
  output logic                                valid
);

  logic [PrioWidth-1:0] best_prio;
  logic [IdW-1:0]       best_id;

  // Scan ids upward; a strict compare keeps the lowest id on ties and,
  // starting from the threshold, excludes priority 0 automatically.
  always_comb begin
    best_prio = thresh;
    best_id   = '0;
    for (int s = 0; s < NrSources; s++) begin
      if (pending[s] && enable[s] && (prio[s] > best_prio)) begin
        best_prio = prio[s];
        best_id   = IdW'(s + 1);
      end
    end
  end

  assign id    = best_id;
  assign valid = (best_id != '0);

endmodule

// File: rtl/ara_irq_router.sv
// ara_irq_router: PLIC-style gateway/arbiter plus CLINT-style msip/mtime
// block behind one register slave port, serving NrHarts harts.
// Context 2h is M-mode of hart h, context 2h+1 is S-mode of hart h.
// Optional build macro ARA_IRQ_SYNC_EN: adds a 2-flop synchroniser on src_i.
module ara_irq_router
  import ara_irq_pkg::*;
#(
  parameter int NrHarts   = 4,
  parameter int NrSources = 8,
  parameter int PrioWidth = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NrSources-1:0]   src_i,
  input  logic                   rtc_i,
  input  logic                   reg_valid_i,
  output logic                   reg_ready_o,
  input  logic                   reg_we_i,
  input  logic [7:0]             reg_addr_i,
  input  logic [31:0]            reg_wdata_i,
  output logic                   reg_rvalid_o,
  output logic [31:0]            reg_rdata_o,
  output logic [2*NrHarts-1:0]   irq_o,
  output logic [NrHarts-1:0]     ipi_o,
  output logic [NrHarts-1:0]     time_irq_o
);

  localparam int NrCtx = 2 * NrHarts;
  localparam int IdW   = clog2(NrSources + 1);

  logic                                ready_p0;
  logic                                wr_en;
  logic                                rd_en;
  logic [NrSources-1:0]                line;
  logic [NrSources-1:0][PrioWidth-1:0] prio;
  logic [NrCtx-1:0][NrSources-1:0]     enable;
  logic [NrCtx-1:0][PrioWidth-1:0]     thresh;
  logic [NrHarts-1:0]                  msip;
  logic [63:0]                         mtime;
  logic [63:0]                         mtime_next;
  logic [NrHarts-1:0][63:0]            mtimecmp;
  gw_state_e                           gw_state [NrSources];
  gw_state_e                           gw_next  [NrSources];
  logic [NrSources-1:0]                pending;
  logic [NrCtx-1:0][IdW-1:0]           arb_id;
  logic [NrCtx-1:0]                    arb_valid;
  logic                                claim_hit;
  logic                                cmpl_hit;
  logic [IdW-1:0]                      claim_id;
  logic [31:0]                         rd_data;
  logic [31:0]                         rdata_p1;
  logic                                rvalid_p1;
  logic [NrCtx-1:0]                    irq_p1;
  logic [NrHarts-1:0]                  ipi_p1;
  logic [NrHarts-1:0]                  tirq_p1;

  assign reg_ready_o  = ready_p0;
  assign wr_en        = reg_valid_i & ready_p0 & reg_we_i;
  assign rd_en        = reg_valid_i & ready_p0 & ~reg_we_i;
  assign reg_rvalid_o = rvalid_p1;
  assign reg_rdata_o  = rdata_p1;
  assign irq_o        = irq_p1;
  assign ipi_o        = ipi_p1;
  assign time_irq_o   = tirq_p1;

`ifdef ARA_IRQ_SYNC_EN
  logic [NrSources-1:0] sync_p0;
  logic [NrSources-1:0] sync_p1;

  // Two-flop synchroniser for asynchronous source lines
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= src_i;
      sync_p1 <= sync_p0;
    end
  end

  assign line = sync_p1;
`else
  assign line = src_i;
`endif

  // Slave is held not-ready during reset and ready forever after
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ready_p0 <= 1'b0;
    else       ready_p0 <= 1'b1;
  end

  // Configuration register writes (priority, enable, threshold, msip, mtimecmp)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio     <= '0;
      enable   <= '0;
      thresh   <= '0;
      msip     <= '0;
      mtimecmp <= '1;
    end else if (wr_en) begin
      for (int s = 1; s <= NrSources; s++) begin
        if (reg_addr_i == REG_PRIO + 8'(s)) prio[s-1] <= reg_wdata_i[PrioWidth-1:0];
      end
      for (int c = 0; c < NrCtx; c++) begin
        if (reg_addr_i == REG_ENABLE + 8'(c)) enable[c] <= reg_wdata_i[NrSources:1];
        if (reg_addr_i == REG_THRESH + 8'(c)) thresh[c] <= reg_wdata_i[PrioWidth-1:0];
      end
      for (int h = 0; h < NrHarts; h++) begin
        if (reg_addr_i == REG_MSIP + 8'(h)) msip[h] <= reg_wdata_i[0];
        if (reg_addr_i == REG_MTIMECMP + 8'(2 * h))     mtimecmp[h][31:0]  <= reg_wdata_i;
        if (reg_addr_i == REG_MTIMECMP + 8'(2 * h + 1)) mtimecmp[h][63:32] <= reg_wdata_i;
      end
    end
  end

  // Timebase: a register write replaces that half and suppresses the tick
  always_comb begin
    mtime_next = mtime;
    if (rtc_i) mtime_next = mtime + 64'd1;
    if (wr_en && (reg_addr_i == REG_MTIME_LO)) mtime_next = {mtime[63:32], reg_wdata_i};
    if (wr_en && (reg_addr_i == REG_MTIME_HI)) mtime_next = {reg_wdata_i, mtime[31:0]};
  end

  // mtime register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mtime <= '0;
    else       mtime <= mtime_next;
  end

  // Claim/complete window decode; claim id is the addressed context's winner
  always_comb begin
    claim_hit = 1'b0;
    cmpl_hit  = 1'b0;
    claim_id  = '0;
    for (int c = 0; c < NrCtx; c++) begin
      if (reg_addr_i == REG_CLAIM + 8'(c)) begin
        claim_hit = rd_en;
        cmpl_hit  = wr_en;
        claim_id  = arb_id[c];
      end
    end
  end

  // Gateway state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < NrSources; s++) gw_state[s] <= GW_IDLE;
    end else begin
      for (int s = 0; s < NrSources; s++) gw_state[s] <= gw_next[s];
    end
  end

  // Gateway next state: level latch, claim hand-off, completion release
  always_comb begin
    for (int s = 0; s < NrSources; s++) begin
      gw_next[s] = gw_state[s];
      pending[s] = (gw_state[s] == GW_PENDING);
      case (gw_state[s])
        GW_IDLE:     if (line[s]) gw_next[s] = GW_PENDING;
        GW_PENDING:  if (claim_hit && (claim_id == IdW'(s + 1))) gw_next[s] = GW_INFLIGHT;
        GW_INFLIGHT: if (cmpl_hit && (reg_wdata_i == 32'(s + 1))) gw_next[s] = GW_IDLE;
        default:     gw_next[s] = GW_IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < NrCtx; c++) begin : g_ctx
    ara_irq_arbiter #(
      .NrSources (NrSources),
      .PrioWidth (PrioWidth),
      .IdW       (IdW)
    ) u_arb (
      .pending (pending),
      .enable  (enable[c]),
      .prio    (prio),
      .thresh  (thresh[c]),
      .id      (arb_id[c]),
      .valid   (arb_valid[c])
    );
  end

  // Read data mux; unmapped addresses read as zero
  always_comb begin
    rd_data = '0;
    for (int s = 1; s <= NrSources; s++) begin
      if (reg_addr_i == REG_PRIO + 8'(s)) rd_data = 32'(prio[s-1]);
    end
    for (int c = 0; c < NrCtx; c++) begin
      if (reg_addr_i == REG_ENABLE + 8'(c)) rd_data = 32'({enable[c], 1'b0});
      if (reg_addr_i == REG_THRESH + 8'(c)) rd_data = 32'(thresh[c]);
      if (reg_addr_i == REG_CLAIM + 8'(c))  rd_data = 32'(arb_id[c]);
    end
    for (int h = 0; h < NrHarts; h++) begin
      if (reg_addr_i == REG_MSIP + 8'(h))             rd_data = 32'(msip[h]);
      if (reg_addr_i == REG_MTIMECMP + 8'(2 * h))     rd_data = mtimecmp[h][31:0];
      if (reg_addr_i == REG_MTIMECMP + 8'(2 * h + 1)) rd_data = mtimecmp[h][63:32];
    end
    if (reg_addr_i == REG_MTIME_LO) rd_data = mtime[31:0];
    if (reg_addr_i == REG_MTIME_HI) rd_data = mtime[63:32];
  end

  // Read response: one cycle after acceptance, writes get no response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_p1 <= 1'b0;
      rdata_p1  <= '0;
    end else begin
      rvalid_p1 <= rd_en;
      if (rd_en) rdata_p1 <= rd_data;
    end
  end

  // ---- output stage: registered interrupt lines ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_p1  <= '0;
      ipi_p1  <= '0;
      tirq_p1 <= '0;
    end else begin
      irq_p1 <= arb_valid;
      ipi_p1 <= msip;
      for (int h = 0; h < NrHarts; h++) tirq_p1[h] <= (mtime >= mtimecmp[h]);
    end
  end

endmodule

// File: tb/tb_ara_irq_router.sv
// Directed self-checking bench for ara_irq_router (NrHarts=4, NrSources=8).
// Build with ARA_IRQ_SYNC_EN defined to exercise the synchronised variant.
module tb_ara_irq_router;

  localparam int NrHarts   = 4;
  localparam int NrSources = 8;
  localparam int PrioWidth = 3;
`ifdef ARA_IRQ_SYNC_EN
  localparam int SyncLat = 2;
`else
  localparam int SyncLat = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NrSources-1:0] src;
  logic                 rtc;
  logic                 reg_valid;
  logic                 reg_ready;
  logic                 reg_we;
  logic [7:0]           reg_addr;
  logic [31:0]          reg_wdata;
  logic                 reg_rvalid;
  logic [31:0]          reg_rdata;
  logic [2*NrHarts-1:0] irq;
  logic [NrHarts-1:0]   ipi;
  logic [NrHarts-1:0]   time_irq;

  int tests = 0;
  int fails = 0;

  ara_irq_router #(
    .NrHarts   (NrHarts),
    .NrSources (NrSources),
    .PrioWidth (PrioWidth)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .src_i        (src),
    .rtc_i        (rtc),
    .reg_valid_i  (reg_valid),
    .reg_ready_o  (reg_ready),
    .reg_we_i     (reg_we),
    .reg_addr_i   (reg_addr),
    .reg_wdata_i  (reg_wdata),
    .reg_rvalid_o (reg_rvalid),
    .reg_rdata_o  (reg_rdata),
    .irq_o        (irq),
    .ipi_o        (ipi),
    .time_irq_o   (time_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    reg_valid = 1'b1;
    reg_we    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    tick();
    reg_valid = 1'b0;
    reg_we    = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    reg_valid = 1'b1;
    reg_we    = 1'b0;
    reg_addr  = a;
    tick();
    reg_valid = 1'b0;
    check({tag, "_rvalid"}, 64'(reg_rvalid), 64'(1'b1));
    check(tag, 64'(reg_rdata), 64'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; src = '0; rtc = 1'b0;
    reg_valid = 1'b0; reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;

    // Reset state
    repeat (3) tick();
    check("rst_ready", 64'(reg_ready), 64'(1'b0));
    check("rst_irq", 64'(irq), 64'(8'h00));
    rst = 1'b0;
    tick();
    check("ready_after_rst", 64'(reg_ready), 64'(1'b1));
    check("irq_after_rst", 64'(irq), 64'(8'h00));
    check("ipi_after_rst", 64'(ipi), 64'(4'h0));
    check("tirq_after_rst", 64'(time_irq), 64'(4'h0));
    rd("mtimecmp0_lo", 8'hB0, 32'hFFFF_FFFF);
    rd("mtimecmp3_hi", 8'hB7, 32'hFFFF_FFFF);

    // Basic claim / complete on context 0
    wr(8'h03, 32'd5);
    wr(8'h20, 32'h08);
    rd("prio3", 8'h03, 32'd5);
    rd("en_ctx0", 8'h20, 32'h08);
    src[2] = 1'b1;
    repeat (1 + SyncLat) tick();
    check("irq0_not_yet", 64'(irq[0]), 64'(1'b0));
    tick();
    check("irq0_asserts", 64'(irq[0]), 64'(1'b1));
    rd("claim3", 8'h60, 32'd3);
    rd("claim_again_none", 8'h60, 32'd0);
    check("irq0_after_claim", 64'(irq[0]), 64'(1'b0));
    wr(8'h60, 32'd3);
    tick();
    check("irq0_repend_wait", 64'(irq[0]), 64'(1'b0));
    tick();
    check("irq0_repend", 64'(irq[0]), 64'(1'b1));
    src[2] = 1'b0;
    repeat (3) tick();
    rd("claim3_cleanup", 8'h60, 32'd3);
    wr(8'h60, 32'd3);

    // Equal priorities, threshold, S-mode context of hart 1
    wr(8'h02, 32'd4);
    wr(8'h05, 32'd4);
    wr(8'h20, 32'h24);
    wr(8'h23, 32'h20);
    src[1] = 1'b1;
    src[4] = 1'b1;
    repeat (2 + SyncLat) tick();
    check("irq0_two_pending", 64'(irq[0]), 64'(1'b1));
    check("irq3_src5", 64'(irq[3]), 64'(1'b1));
    rd("claim_tie_low_id", 8'h60, 32'd2);
    wr(8'h40, 32'd4);
    tick();
    check("irq0_thresh_block", 64'(irq[0]), 64'(1'b0));
    check("irq3_unaffected", 64'(irq[3]), 64'(1'b1));
    rd("claim_thresh_none", 8'h60, 32'd0);
    rd("claim_ctx3", 8'h63, 32'd5);
    tick();
    check("irq3_after_claim", 64'(irq[3]), 64'(1'b0));
    src[1] = 1'b0;
    src[4] = 1'b0;
    repeat (3) tick();
    wr(8'h60, 32'd2);
    wr(8'h60, 32'd5);
    wr(8'h40, 32'd0);
    wr(8'h23, 32'd0);

    // Software interrupt
    wr(8'h81, 32'd1);
    check("ipi_latency", 64'(ipi), 64'(4'h0));
    tick();
    check("ipi1_set", 64'(ipi), 64'(4'b0010));
    rd("msip1", 8'h81, 32'd1);
    wr(8'h81, 32'd0);
    tick();
    check("ipi1_clr", 64'(ipi), 64'(4'h0));

    // Spurious completes are ignored
    wr(8'h07, 32'd2);
    wr(8'h20, 32'h80);
    src[6] = 1'b1;
    repeat (2 + SyncLat) tick();
    check("irq0_src7", 64'(irq[0]), 64'(1'b1));
    wr(8'h60, 32'd7);
    wr(8'h60, 32'd0);
    tick();
    check("irq0_spurious_cmpl", 64'(irq[0]), 64'(1'b1));
    rd("claim7", 8'h60, 32'd7);
    wr(8'h60, 32'd39);
    tick();
    check("irq0_bad_id_cmpl", 64'(irq[0]), 64'(1'b0));
    rd("claim7_still_inflight", 8'h60, 32'd0);

    // Unmapped reads
    rd("unmapped_ff", 8'hFF, 32'd0);
    rd("unmapped_prio0", 8'h00, 32'd0);
    rd("unmapped_ctx8", 8'h28, 32'd0);
    rd("unmapped_src9", 8'h09, 32'd0);

    // Timer compare and tick
    wr(8'hA0, 32'd10);
    wr(8'hB2, 32'd12);
    wr(8'hB3, 32'd0);
    tick();
    check("tirq_below", 64'(time_irq), 64'(4'h0));
    rtc = 1'b1; tick(); rtc = 1'b0;
    tick();
    check("tirq_at_11", 64'(time_irq), 64'(4'h0));
    rtc = 1'b1; tick(); rtc = 1'b0;
    check("tirq_latency", 64'(time_irq), 64'(4'h0));
    tick();
    check("tirq1_at_12", 64'(time_irq), 64'(4'b0010));
    rd("mtime_12", 8'hA0, 32'd12);
    rtc = 1'b1;
    wr(8'hA0, 32'd100);
    rtc = 1'b0;
    rd("mtime_write_wins", 8'hA0, 32'd100);
    rd("mtime_hi_0", 8'hA1, 32'd0);
    wr(8'hA1, 32'hFFFF_FFFF);
    wr(8'hA0, 32'hFFFF_FFFF);
    tick();
    check("tirq_all_max", 64'(time_irq), 64'(4'hF));
    rtc = 1'b1; tick(); rtc = 1'b0;
    check("tirq_wrap_latency", 64'(time_irq), 64'(4'hF));
    tick();
    check("tirq_after_wrap", 64'(time_irq), 64'(4'h0));
    rd("mtime_wrap_lo", 8'hA0, 32'd0);
    rd("mtime_wrap_hi", 8'hA1, 32'd0);

    // Reset in the middle of a pending claim
    wr(8'h60, 32'd7);
    repeat (2) tick();
    check("irq0_before_rst", 64'(irq[0]), 64'(1'b1));
    reg_valid = 1'b1;
    reg_we    = 1'b0;
    reg_addr  = 8'h60;
    rst       = 1'b1;
    src       = '0;
    tick();
    check("rst_no_rvalid", 64'(reg_rvalid), 64'(1'b0));
    check("rst_irq_clear", 64'(irq), 64'(8'h00));
    check("rst_mid_ready", 64'(reg_ready), 64'(1'b0));
    rst       = 1'b0;
    reg_valid = 1'b0;
    tick();
    check("ready_after_mid_rst", 64'(reg_ready), 64'(1'b1));
    check("no_rvalid_after_rst", 64'(reg_rvalid), 64'(1'b0));
    rd("prio7_cleared", 8'h07, 32'd0);
    wr(8'h07, 32'd2);
    wr(8'h20, 32'h80);
    rd("gw_idle_after_rst", 8'h60, 32'd0);
    check("irq0_idle_after_rst", 64'(irq[0]), 64'(1'b0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
